// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master arbiter for the shared data RAM port, one outstanding read
// RAM_ARB_RR_EN selects round-robin contention; undefined gives m0 fixed priority.
module ram_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req,
  input  logic             m1_req,
  input  logic             m0_we,
  input  logic             m1_we,
  input  logic [3:0]       m0_sel,
  input  logic [3:0]       m1_sel,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m0_gnt,
  output logic             m1_gnt,
  output logic             m0_rvalid,
  output logic             m1_rvalid,
  output logic             m0_rerr,
  output logic             m1_rerr,
  output logic [WIDTH-1:0] m_rdata,
  output logic             ram_ce,
  output logic             ram_we,
  output logic [3:0]       ram_sel,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_data_out,
  input  logic             ram_rvalid,
  input  logic [WIDTH-1:0] ram_data_in
);

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_e;

  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [7:0] tcnt_q, tcnt_d;

  logic rsp, timeout, slot, win, gnt_any, win_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    rsp     = (state_q == RD_WAIT) && (ram_rvalid || (tcnt_q == TLIM));
    timeout = (state_q == RD_WAIT) && !ram_rvalid && (tcnt_q == TLIM);
    slot    = (state_q == IDLE) || rsp;
`ifdef RAM_ARB_RR_EN
    win     = (m0_req && m1_req) ? ~last_q : m1_req;
`else
    win     = ~m0_req;
`endif
    // Outputs are gated by rst_n so every output is 0 while reset is held.
    gnt_any = rst_n && slot && (m0_req || m1_req);
    win_we  = win ? m1_we : m0_we;

    m0_gnt       = gnt_any && !win;
    m1_gnt       = gnt_any && win;
    ram_ce       = gnt_any;
    ram_we       = gnt_any && win_we;
    ram_sel      = gnt_any ? (win ? m1_sel : m0_sel) : 4'd0;
    ram_addr     = gnt_any ? (win ? m1_addr : m0_addr) : '0;
    ram_data_out = gnt_any ? (win ? m1_wdata : m0_wdata) : '0;

    m0_rvalid = rst_n && rsp && !owner_q;
    m1_rvalid = rst_n && rsp && owner_q;
    m0_rerr   = rst_n && timeout && !owner_q;
    m1_rerr   = rst_n && timeout && owner_q;
    m_rdata   = (rst_n && rsp && ram_rvalid) ? ram_data_in : '0;

    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    if (state_q == RD_WAIT) tcnt_d = tcnt_q + 8'd1;
    if (slot) state_d = IDLE;
    if (gnt_any) begin
      last_d = win;
      if (!win_we) begin
        state_d = RD_WAIT;
        owner_d = win;
        tcnt_d  = 8'd0;
      end
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter that shares the single data RAM port between the core's load/store interface (master 0) and a secondary requester such as a program loader or DMA engine (master 1). It sits between `core_top`'s `ram_*` outputs and the RAM. Each RAM access is sequenced through a small FSM, with at most one outstanding read. Read responses are routed back to the issuing master, and a timeout watchdog guarantees a response.

## Interface
- `WIDTH`, 32, address and data width.
- `TIMEOUT`, 16, cycles spent in RD_WAIT without `ram_rvalid` before an error response is forced; legal range 2–255.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  access request; held until granted.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_sel`, `m1_sel`  in  4  byte lane enables.
- `m0_addr`, `m1_addr`  in  WIDTH  byte address.
- `m0_wdata`, `m1_wdata`  in  WIDTH  write data.
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid`  out  1  read response valid, 1-cycle pulse.
- `m0_rerr`, `m1_rerr`  out  1  response produced by timeout; coincides with rvalid.
- `m_rdata`  out  WIDTH  shared read data; 0 when rerr=1.
- `ram_ce`, `ram_we`  out  1  RAM strobe and write enable.
- `ram_sel`  out  4  RAM byte lanes.
- `ram_addr`, `ram_data_out`  out  WIDTH  RAM address and write data.
- `ram_rvalid`  in  1  RAM read data valid.
- `ram_data_in`  in  WIDTH  RAM read data.

## Operation
- FSM states: IDLE and RD_WAIT.
  - Registered state: `owner` (1 bit), `last` (1 bit, last master served), timeout counter `tcnt` (8 bit).
- Arbitration slot: exists in IDLE, and in RD_WAIT during the cycle `ram_rvalid`=1 or the timeout fires.
  - In a slot, a single requester is granted.
  - When both request, the winner is the master ≠ `last` (see Configuration).
- Grant cycle: exactly one of `mX_gnt`=1, and `ram_ce`=1.
  - `ram_we`, `ram_sel`, `ram_addr` and `ram_data_out` are muxed from the winner.
  - `last` ← winner.
  - With no grant, `ram_ce`=0, `ram_we`=0, and the other RAM outputs are 0.
- Write grant: the access completes in the grant cycle. The state stays or returns to IDLE.
- Read grant: `owner` ← winner, `tcnt` ← 0, next state RD_WAIT.
- RD_WAIT:
  - No grants except in the slot cycle.
  - `tcnt` increments every cycle.
  - On `ram_rvalid`=1: `m<owner>_rvalid`=1 and `m_rdata`=`ram_data_in`.
  - On `tcnt`==TIMEOUT-1 without `ram_rvalid`: `m<owner>_rvalid`=1, `m<owner>_rerr`=1, `m_rdata`=0.
  - After either event, the next state follows the same-cycle arbitration result, or IDLE if there is no grant.
- `ram_rvalid` in IDLE is ignored: no rvalid to either master.
- A late `ram_rvalid` arriving after a timeout is also ignored when the FSM is back in IDLE.
- `m_rdata` is 0 whenever no rvalid is asserted.

## Timing
- Reset values: state=IDLE, `owner`=0, `last`=1 (so m0 wins the first contention), `tcnt`=0.
  - All outputs are 0 during reset.
- Write latency: 0 cycles to grant when the port is free.
- Read latency: grant at cycle N, response no earlier than N+1 (the RAM's one-cycle `ram_rvalid`).
- Back-to-back reads: the next grant can issue in the same cycle as the previous response. Peak throughput is one read per cycle with 1-cycle RAM.
- Reset asserted in RD_WAIT: the FSM returns to IDLE immediately and the pending response is dropped.
- Grants are combinational from `mX_req`, state and `last`. No combinational path exists from `ram_rvalid` to the RAM outputs other than through the slot condition.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin. On contention the master ≠ `last` wins, so no master is starved.
- `RAM_ARB_RR_EN` undefined: fixed priority, m0 (core) always wins contention. `last` is still updated but is unused for arbitration.

## Test plan
- Single write: m0_req=1, we=1, addr=0x10, wdata=0xDEADBEEF, sel=0xF → m0_gnt=1 and ram_ce=ram_we=1 with those values in the same cycle; the state remains IDLE.
- Single read: m1 reads 0x20, RAM returns 0x12345678 one cycle later → m1_rvalid pulses for 1 cycle with m_rdata=0x12345678; m0_rvalid stays 0.
- Contention with RR: both hold read requests for 4 reads → grant order m0, m1, m0, m1. Without `RAM_ARB_RR_EN` → m0 for all 4 while m0_req is held.
- Back-to-back: m0 issues reads to 0x0 and then 0x4 → second grant coincides with the first rvalid; responses arrive in 2 consecutive cycles.
- Timeout: with TIMEOUT=16, the RAM never asserts rvalid after an m1 read → at the 16th RD_WAIT cycle m1_rvalid=m1_rerr=1 and m_rdata=0; a later stray ram_rvalid produces no rvalid.
- Reset mid-read: rst_n=0 during RD_WAIT → all outputs are 0 immediately. After release, a fresh m0 read is granted from IDLE and the old response is never delivered.
